dot_matrix_capture: RTL and testbench

DOT_MATRIX_CAPTURE -- requirements
Module: dot_matrix_capture

---
 rtl/dot_matrix_pkg.sv | 48 ++++
 rtl/dot_row_decode.sv | 26 ++
 rtl/dot_matrix_capture.sv | 138 +++++++++++++
 tb/tb_dot_matrix_capture.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dot_matrix_pkg.sv
// Shared dot-matrix definitions: glyph bitmaps, row-strobe constants, capture FSM states.
// Latency: n/a (constants and a combinational classifier only).
// Backpressure: n/a.
package dot_matrix_pkg;

  localparam int NUM_ROWS = 8;

  // Row strobe is active-low one-cold; all ones means no row is being driven.
  localparam logic [7:0] ROW_BLANK = 8'hFF;
  localparam logic [7:0] ROW0_STROBE = 8'b0111_1111;
  localparam logic [7:0] ROW7_STROBE = 8'b1111_1110;

  // Glyph bitmaps, row 0 in the most significant byte.
  localparam logic [63:0] GLYPH0 = 64'h0C0C_197E_9818_2848;
  localparam logic [63:0] GLYPH1 = 64'h0024_3CBD_FF3C_3C00;
  localparam logic [63:0] GLYPH2 = 64'h1818_3C3C_5A18_1824;

  localparam logic [1:0] PAT_UNKNOWN = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] id;
    logic       hit;
  } class_t;

  // Priority match against the glyph table; lowest index wins.
  function automatic class_t classify(input logic [63:0] frm);
    class_t res;
    res.id  = PAT_UNKNOWN;
    res.hit = 1'b0;
    if (frm == GLYPH0) begin
      res.id  = 2'b00;
      res.hit = 1'b1;
    end else if (frm == GLYPH1) begin
      res.id  = 2'b01;
      res.hit = 1'b1;
    end else if (frm == GLYPH2) begin
      res.id  = 2'b10;
      res.hit = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dot_row_decode.sv
// Decodes an active-low one-cold row strobe into {valid, index}.
// Latency: combinational.
// Backpressure: none.
module dot_row_decode
  import dot_matrix_pkg::*;
(
  input  logic [7:0] dot_row,
  output logic       valid,
  output logic [2:0] index
);

  logic [7:0] zeros;

  // Exactly one low bit is a strobe; bit7 low maps to row 0, bit0 low to row 7.
  always_comb begin
    zeros = ~dot_row;
    valid = ($countones(zeros) == 1);
    index = 3'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (zeros[i]) begin
        index = 3'(7 - i);
      end
    end
  end

endmodule

// File: rtl/dot_matrix_capture.sv
// Captures an 8-row scanned dot-matrix into a 64-bit frame and classifies it against known glyphs.
// Latency: frame/frame_valid/pattern_id/match registered one clock after row 7 is presented.
// Backpressure: none; rows are consumed every clock, protocol violations pulse seq_err.
module dot_matrix_capture
  import dot_matrix_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  dot_row,
  input  logic [7:0]  dot_col,
  output logic [63:0] frame,
  output logic        frame_valid,
  output logic [1:0]  pattern_id,
  output logic        match,
  output logic        seq_err,
  output logic [7:0]  frame_count
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] exp_row;
  logic [2:0] exp_row_nxt;

  // Rows 0..6 are buffered; row 7 is taken straight from dot_col when the frame closes.
  logic [7:0] line_buf [0:6];

  logic        row_vld;
  logic [2:0]  row_idx;
  logic        line_we;
  logic [2:0]  line_idx;
  logic        frame_load;
  logic        seq_err_nxt;
  logic [63:0] assembled;
  class_t      cls;

  dot_row_decode u_decode (
    .dot_row (dot_row),
    .valid   (row_vld),
    .index   (row_idx)
  );

  assign assembled = {line_buf[0], line_buf[1], line_buf[2], line_buf[3],
                      line_buf[4], line_buf[5], line_buf[6], dot_col};
  assign cls = classify(assembled);

  // State and expected-row register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      exp_row <= 3'd0;
    end else begin
      state   <= state_nxt;
      exp_row <= exp_row_nxt;
    end
  end

  // Next-state and datapath control; a row-0 strobe always (re)starts a frame.
  always_comb begin
    state_nxt   = state;
    exp_row_nxt = exp_row;
    line_we     = 1'b0;
    line_idx    = row_idx;
    frame_load  = 1'b0;
    seq_err_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (row_vld && row_idx == 3'd0) begin
          line_we     = 1'b1;
          exp_row_nxt = 3'd1;
          state_nxt   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (row_vld && row_idx == exp_row) begin
          if (row_idx == 3'd7) begin
            frame_load  = 1'b1;
            exp_row_nxt = 3'd0;
            state_nxt   = ST_IDLE;
          end else begin
            line_we     = 1'b1;
            exp_row_nxt = exp_row + 3'd1;
          end
        end else if (row_vld && row_idx == 3'd0) begin
          // Restart: the partial frame is dropped and this row begins a new one.
          seq_err_nxt = 1'b1;
          line_we     = 1'b1;
          exp_row_nxt = 3'd1;
          state_nxt   = ST_CAPTURE;
        end else begin
          seq_err_nxt = 1'b1;
          exp_row_nxt = 3'd0;
          state_nxt   = ST_IDLE;
        end
      end
      default: begin
        exp_row_nxt = 3'd0;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

  // Line buffer writes for rows 0..6.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) begin
        line_buf[i] <= 8'h00;
      end
    end else if (line_we) begin
      for (int i = 0; i < 7; i++) begin
        if (line_idx == 3'(i)) begin
          line_buf[i] <= dot_col;
        end
      end
    end
  end

  // Output registers; frame and classification hold until the next completed frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame       <= 64'd0;
      frame_valid <= 1'b0;
      pattern_id  <= PAT_UNKNOWN;
      match       <= 1'b0;
      seq_err     <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_valid <= frame_load;
      seq_err     <= seq_err_nxt;
      if (frame_load) begin
        frame       <= assembled;
        pattern_id  <= cls.id;
        match       <= cls.hit;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dot_matrix_capture.sv
// Scoreboard bench for dot_matrix_capture: directed scans push expected events, a monitor checks them.
// Latency: expects outputs one clock after row 7 / the offending row.
// Backpressure: n/a.
module tb_dot_matrix_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  dot_row;
  logic [7:0]  dot_col;
  logic [63:0] frame;
  logic        frame_valid;
  logic [1:0]  pattern_id;
  logic        match;
  logic        seq_err;
  logic [7:0]  frame_count;

  localparam logic [63:0] G0 = 64'h0C0C_197E_9818_2848;
  localparam logic [63:0] G1 = 64'h0024_3CBD_FF3C_3C00;
  localparam logic [63:0] G2 = 64'h1818_3C3C_5A18_1824;
  localparam logic [63:0] ALL_ON = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    bit          is_frame;
    logic [63:0] frm;
    logic [1:0]  id;
    logic        m;
    logic [7:0]  cnt;
    int          gap;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_fv = 0;
  logic [7:0] exp_cnt = 8'd0;

  dot_matrix_capture dut (
    .clock       (clock),
    .reset       (reset),
    .dot_row     (dot_row),
    .dot_col     (dot_col),
    .frame       (frame),
    .frame_valid (frame_valid),
    .pattern_id  (pattern_id),
    .match       (match),
    .seq_err     (seq_err),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (frame_valid || seq_err)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event frame_valid=%0b seq_err=%0b expected=none (cycle %0d)",
                 frame_valid, seq_err, cyc);
      end else begin
        e = sb.pop_front();
        if (e.is_frame) begin
          check("ev_frame_valid", 64'(frame_valid), 64'd1);
          check("ev_no_seq_err", 64'(seq_err), 64'd0);
          check("frame", frame, e.frm);
          check("pattern_id", 64'(pattern_id), 64'(e.id));
          check("match", 64'(match), 64'(e.m));
          check("frame_count", 64'(frame_count), 64'(e.cnt));
          if (e.gap != 0) check("fv_spacing", 64'(cyc - last_fv), 64'(e.gap));
        end else begin
          check("ev_seq_err", 64'(seq_err), 64'd1);
          check("ev_no_frame_valid", 64'(frame_valid), 64'd0);
        end
      end
      if (frame_valid) last_fv = cyc;
    end
  end

  function automatic logic [7:0] strobe(input int i);
    return ~(8'h80 >> i);
  endfunction

  function automatic logic [7:0] grow(input logic [63:0] g, input int i);
    return g[63 - 8*i -: 8];
  endfunction

  task automatic step(input logic [7:0] r, input logic [7:0] c);
    dot_row = r;
    dot_col = c;
    @(posedge clock);
    #1;
  endtask

  task automatic push_seq();
    exp_t e;
    e.is_frame = 1'b0;
    e.frm = '0; e.id = '0; e.m = 1'b0; e.cnt = '0; e.gap = 0;
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [63:0] g, input logic [1:0] id, input logic m, input int gap);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.is_frame = 1'b1;
    e.frm = g; e.id = id; e.m = m; e.cnt = exp_cnt; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [63:0] g, input logic [1:0] id, input logic m, input int gap);
    push_frame(g, id, m, gap);
    for (int i = 0; i < 8; i++) step(strobe(i), grow(g, i));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_frame"}, frame, 64'd0);
    check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
    check({tag, "_pattern_id"}, 64'(pattern_id), 64'd3);
    check({tag, "_match"}, 64'(match), 64'd0);
    check({tag, "_seq_err"}, 64'(seq_err), 64'd0);
    check({tag, "_frame_count"}, 64'(frame_count), 64'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step(strobe(5), 8'hA5);
    exp_cnt = 8'd0;
    check_reset_state("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    dot_row = 8'hFF;
    dot_col = 8'h00;
    do_reset(2);

    // Glyph 1 frame.
    send_frame(G1, 2'b01, 1'b1, 0);
    repeat (3) step(8'hFF, 8'h00);
    check("hold_frame", frame, G1);
    check("hold_pattern_id", 64'(pattern_id), 64'd1);
    check("hold_match", 64'(match), 64'd1);

    // All-on frame is not a glyph.
    send_frame(ALL_ON, 2'b11, 1'b0, 0);
    step(8'hFF, 8'h00);
    check("hold_all_on", frame, ALL_ON);

    // Skipped row (0,1,2,4) then a clean glyph 0.
    push_seq();
    step(strobe(0), 8'h11); step(strobe(1), 8'h22); step(strobe(2), 8'h33); step(strobe(4), 8'h44);
    send_frame(G0, 2'b00, 1'b0 | 1'b1, 0);

    // Multi-zero strobe mid-capture, then a stray row 1 that IDLE must ignore.
    push_seq();
    step(strobe(0), 8'h01); step(strobe(1), 8'h02); step(strobe(2), 8'h03);
    step(8'b0011_1111, 8'h04);
    step(strobe(1), 8'h05);
    step(8'hFF, 8'h00);

    // Blank mid-capture.
    push_seq();
    step(strobe(0), 8'h01); step(strobe(1), 8'h02); step(8'hFF, 8'h00);

    // Row 0 mid-capture restarts; the restarted frame completes as glyph 0.
    push_seq();
    step(strobe(0), 8'hEE); step(strobe(1), 8'hDD);
    push_frame(G0, 2'b00, 1'b1, 0);
    for (int i = 0; i < 8; i++) step(strobe(i), grow(G0, i));
    step(8'hFF, 8'h00);

    // Reset partway through glyph 2, then a full glyph 2.
    for (int i = 0; i < 5; i++) step(strobe(i), grow(G2, i));
    do_reset(1);
    send_frame(G2, 2'b10, 1'b1, 0);
    step(8'hFF, 8'h00);
    check("after_reset_count", 64'(frame_count), 64'd1);

    // 256 back-to-back glyph 0 frames from a fresh reset.
    do_reset(1);
    for (int f = 0; f < 256; f++) send_frame(G0, 2'b00, 1'b1, (f == 0) ? 0 : 8);
    repeat (4) step(8'hFF, 8'h00);
    check("wrap_frame_count", 64'(frame_count), 64'd0);
    check("drain_queue", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
